// File: rtl/unidade_controle.sv
// unidade_controle: control unit for the stack processor.
// Fetches 16-bit instructions from a synchronous ROM, decodes them and
// sequences the datapath as SET/PULSE micro-op pairs with registered strobes.
// Optional feature: define UC_CALL_RET_EN to build CALL/RET with an internal
// RS_DEPTH-entry return stack (otherwise 0x06/0x07 execute as NOP).
module unidade_controle #(
    parameter int PC_W     = 8,
    parameter int RS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            data_uc,
    output logic            clk_pilha,
    output logic            clk_temp1,
    output logic            clk_temp2,
    output logic            wren,
    output logic            controle_pilha,
    output logic            load_temp1,
    output logic            load_temp2,
    output logic [15:0]     din_UC,
    output logic [4:0]      opcode,
    output logic            halt
);

    localparam logic [4:0] OP_PUSH = 5'h01;
    localparam logic [4:0] OP_POP  = 5'h02;
    localparam logic [4:0] OP_JMP  = 5'h04;
    localparam logic [4:0] OP_JC   = 5'h05;
    localparam logic [4:0] OP_HALT = 5'h1F;
`ifdef UC_CALL_RET_EN
    localparam logic [4:0] OP_CALL = 5'h06;
    localparam logic [4:0] OP_RET  = 5'h07;
`endif

    typedef enum logic [2:0] {FETCH, DECODE, LIT_WAIT, LIT, SET, PULSE, HALTED} state_t;
    typedef enum logic [2:0] {UOP_PUSH_LIT, UOP_POP, UOP_LOAD_T1, UOP_LOAD_T2, UOP_PUSH_RES} uop_t;

    state_t          state, state_nxt;
    uop_t            uop, uop_nxt;
    logic [2:0]      alu_step, alu_step_nxt;
    logic            alu_mode, alu_mode_nxt;
    logic            flag, flag_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     din_nxt;
    logic [4:0]      opcode_nxt;
    logic            pilha_nxt, temp1_nxt, temp2_nxt;
    logic            wren_nxt, ctrl_nxt, lt1_nxt, lt2_nxt, halt_nxt;

    logic [4:0]      op;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            unused_instr;

    assign op           = instr[15:11];
    assign target       = instr[PC_W-1:0];
    assign pc_inc       = pc + PC_W'(1);
    assign unused_instr = &{1'b0, instr};

    // ALU sequence order: load T1, pop, load T2, pop, push result
    function automatic uop_t alu_uop(input logic [2:0] step);
        uop_t u;
        case (step)
            3'd0:       u = UOP_LOAD_T1;
            3'd1, 3'd3: u = UOP_POP;
            3'd2:       u = UOP_LOAD_T2;
            default:    u = UOP_PUSH_RES;
        endcase
        return u;
    endfunction

`ifdef UC_CALL_RET_EN
    localparam int RS_IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int RS_CNT_W = $clog2(RS_DEPTH + 1);

    logic [PC_W-1:0]     rs_mem [RS_DEPTH];
    logic [RS_CNT_W-1:0] rs_cnt;
    logic                rs_push, rs_pop, rs_full, rs_empty;
    logic [RS_IDX_W-1:0] rs_top_idx;

    assign rs_full    = (rs_cnt == RS_CNT_W'(RS_DEPTH));
    assign rs_empty   = (rs_cnt == '0);
    assign rs_top_idx = RS_IDX_W'(rs_cnt - RS_CNT_W'(1));

    // Return addresses are written at the current fill level
    always_ff @(posedge clk) begin
        if (rs_push)
            rs_mem[rs_cnt[RS_IDX_W-1:0]] <= pc_inc;
    end

    // Return-stack fill level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rs_cnt <= '0;
        else if (rs_push)
            rs_cnt <= rs_cnt + RS_CNT_W'(1);
        else if (rs_pop)
            rs_cnt <= rs_cnt - RS_CNT_W'(1);
    end
`endif

    // Next state, micro-op progress, PC and registered data values
    always_comb begin
        state_nxt    = state;
        uop_nxt      = uop;
        alu_step_nxt = alu_step;
        alu_mode_nxt = alu_mode;
        flag_nxt     = flag;
        pc_nxt       = pc;
        din_nxt      = din_UC;
        opcode_nxt   = opcode;
`ifdef UC_CALL_RET_EN
        rs_push      = 1'b0;
        rs_pop       = 1'b0;
`endif
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                pc_nxt    = pc_inc;
                state_nxt = FETCH;
                if (op == OP_PUSH) begin
                    state_nxt    = LIT_WAIT;
                    uop_nxt      = UOP_PUSH_LIT;
                    alu_mode_nxt = 1'b0;
                end else if (op == OP_POP) begin
                    state_nxt    = SET;
                    uop_nxt      = UOP_POP;
                    alu_mode_nxt = 1'b0;
                end else if (op == OP_JMP) begin
                    pc_nxt = target;
                end else if (op == OP_JC) begin
                    if (flag)
                        pc_nxt = target;
                end else if (op == OP_HALT) begin
                    state_nxt = HALTED;
`ifdef UC_CALL_RET_EN
                end else if (op == OP_CALL) begin
                    if (rs_full) begin
                        state_nxt = HALTED;
                    end else begin
                        rs_push = 1'b1;
                        pc_nxt  = target;
                    end
                end else if (op == OP_RET) begin
                    if (rs_empty) begin
                        state_nxt = HALTED;
                    end else begin
                        rs_pop = 1'b1;
                        pc_nxt = rs_mem[rs_top_idx];
                    end
`endif
                end else if (op[4]) begin
                    state_nxt    = SET;
                    alu_mode_nxt = 1'b1;
                    alu_step_nxt = 3'd0;
                    uop_nxt      = UOP_LOAD_T1;
                    opcode_nxt   = op;
                end
            end
            LIT_WAIT: state_nxt = LIT;
            LIT: begin
                din_nxt   = instr;
                pc_nxt    = pc_inc;
                state_nxt = SET;
            end
            SET: state_nxt = PULSE;
            PULSE: begin
                if (uop == UOP_PUSH_RES)
                    flag_nxt = data_uc;
                if (alu_mode && (alu_step != 3'd4)) begin
                    alu_step_nxt = alu_step + 3'd1;
                    uop_nxt      = alu_uop(alu_step + 3'd1);
                    state_nxt    = SET;
                end else begin
                    state_nxt = FETCH;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    // Strobe/control values for the coming cycle, so every output is a flop
    always_comb begin
        pilha_nxt = 1'b0;
        temp1_nxt = 1'b0;
        temp2_nxt = 1'b0;
        wren_nxt  = 1'b0;
        ctrl_nxt  = 1'b0;
        lt1_nxt   = 1'b0;
        lt2_nxt   = 1'b0;
        halt_nxt  = (state_nxt == HALTED);
        if ((state_nxt == SET) || (state_nxt == PULSE)) begin
            case (uop_nxt)
                UOP_PUSH_LIT: wren_nxt = 1'b1;
                UOP_LOAD_T1:  lt1_nxt  = 1'b1;
                UOP_LOAD_T2:  lt2_nxt  = 1'b1;
                UOP_PUSH_RES: begin
                    wren_nxt = 1'b1;
                    ctrl_nxt = 1'b1;
                end
                default: wren_nxt = 1'b0;
            endcase
            if (state_nxt == PULSE) begin
                temp1_nxt = (uop_nxt == UOP_LOAD_T1);
                temp2_nxt = (uop_nxt == UOP_LOAD_T2);
                pilha_nxt = (uop_nxt != UOP_LOAD_T1) && (uop_nxt != UOP_LOAD_T2);
            end
        end
    end

    // State, sequencing registers, PC and data outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            uop      <= UOP_PUSH_LIT;
            alu_step <= 3'd0;
            alu_mode <= 1'b0;
            flag     <= 1'b0;
            pc       <= '0;
            din_UC   <= '0;
            opcode   <= '0;
        end else begin
            state    <= state_nxt;
            uop      <= uop_nxt;
            alu_step <= alu_step_nxt;
            alu_mode <= alu_mode_nxt;
            flag     <= flag_nxt;
            pc       <= pc_nxt;
            din_UC   <= din_nxt;
            opcode   <= opcode_nxt;
        end
    end

    // Registered strobes and controls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_pilha      <= 1'b0;
            clk_temp1      <= 1'b0;
            clk_temp2      <= 1'b0;
            wren           <= 1'b0;
            controle_pilha <= 1'b0;
            load_temp1     <= 1'b0;
            load_temp2     <= 1'b0;
            halt           <= 1'b0;
        end else begin
            clk_pilha      <= pilha_nxt;
            clk_temp1      <= temp1_nxt;
            clk_temp2      <= temp2_nxt;
            wren           <= wren_nxt;
            controle_pilha <= ctrl_nxt;
            load_temp1     <= lt1_nxt;
            load_temp2     <= lt2_nxt;
            halt           <= halt_nxt;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: bench for the stack-processor control unit.
// A synchronous ROM model feeds the DUT; an instruction-level reference model
// predicts strobe events, fetch addresses and the halt cycle.
module tb_unidade_controle;

    localparam int PC_W    = 8;
    localparam int MAX_CYC = 600;
    localparam int K_PILHA = 0;
    localparam int K_T1    = 1;
    localparam int K_T2    = 2;
    localparam logic [15:0] W_HALT = 16'hF800;

    typedef struct {
        int          cyc;
        int          kind;
        logic        wren;
        logic        cp;
        logic        lt1;
        logic        lt2;
        logic        chk_din;
        logic [15:0] din;
        logic        chk_opc;
        logic [4:0]  opc;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic            data_uc;
    logic            clk_pilha, clk_temp1, clk_temp2;
    logic            wren, controle_pilha, load_temp1, load_temp2;
    logic [15:0]     din_UC;
    logic [4:0]      opcode;
    logic            halt;

    logic [15:0] rom [256];
    logic        dflag [MAX_CYC + 16];

    ev_t         obs_ev[$];
    logic [7:0]  obs_pc [MAX_CYC];
    int          obs_halt_cyc;
    int          shape_bad;

    ev_t         exp_ev[$];
    logic [7:0]  exp_fetch_pc [MAX_CYC];
    logic        exp_is_fetch [MAX_CYC];
    int          exp_halt_cyc;

    int n_checks = 0;
    int n_errors = 0;

    // Free-running system clock
    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address
    always @(posedge clk) instr <= rom[pc];

    unidade_controle #(.PC_W(PC_W), .RS_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instr          (instr),
        .data_uc        (data_uc),
        .clk_pilha      (clk_pilha),
        .clk_temp1      (clk_temp1),
        .clk_temp2      (clk_temp2),
        .wren           (wren),
        .controle_pilha (controle_pilha),
        .load_temp1     (load_temp1),
        .load_temp2     (load_temp2),
        .din_UC         (din_UC),
        .opcode         (opcode),
        .halt           (halt)
    );

    function automatic logic [15:0] enc(input logic [4:0] o, input logic [7:0] t);
        return {o, 3'b000, t};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = W_HALT;
    endtask

    task automatic fill_dflag(input logic v);
        for (int i = 0; i < MAX_CYC + 16; i++) dflag[i] = v;
    endtask

    // Instruction-level model: cycle cost per instruction and its datapath events
    task automatic add_ev(input int budget, input int cyc, input int kind,
                          input logic w, input logic cp, input logic l1, input logic l2,
                          input logic cd, input logic [15:0] d, input logic co, input logic [4:0] o);
        ev_t e;
        if (cyc < budget) begin
            e.cyc = cyc; e.kind = kind; e.wren = w; e.cp = cp; e.lt1 = l1; e.lt2 = l2;
            e.chk_din = cd; e.din = d; e.chk_opc = co; e.opc = o;
            exp_ev.push_back(e);
        end
    endtask

    task automatic run_model(input int budget);
        logic [7:0] mpc;
        logic       mflag;
        logic       done;
        int         c;
        logic [4:0] o;
        logic [7:0] t;
`ifdef UC_CALL_RET_EN
        logic [7:0] rstk[$];
        rstk.delete();
`endif
        exp_ev.delete();
        for (int i = 0; i < MAX_CYC; i++) exp_is_fetch[i] = 1'b0;
        exp_halt_cyc = -1;
        mpc = 8'h00; mflag = 1'b0; done = 1'b0; c = 0;
        while (!done && c < budget) begin
            exp_is_fetch[c] = 1'b1;
            exp_fetch_pc[c] = mpc;
            o = rom[mpc][15:11];
            t = rom[mpc][7:0];
            if (o == 5'h1F) begin
                exp_halt_cyc = c + 2;
                done = 1'b1;
            end else if (o == 5'h01) begin
                add_ev(budget, c + 5, K_PILHA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rom[mpc + 8'd1], 1'b0, 5'h00);
                mpc = mpc + 8'd2; c += 6;
            end else if (o == 5'h02) begin
                add_ev(budget, c + 3, K_PILHA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 5'h00);
                mpc = mpc + 8'd1; c += 4;
            end else if (o == 5'h04) begin
                mpc = t; c += 2;
            end else if (o == 5'h05) begin
                mpc = mflag ? t : mpc + 8'd1; c += 2;
`ifdef UC_CALL_RET_EN
            end else if (o == 5'h06) begin
                if (rstk.size() >= 4) begin
                    exp_halt_cyc = c + 2; done = 1'b1;
                end else begin
                    rstk.push_back(mpc + 8'd1); mpc = t; c += 2;
                end
            end else if (o == 5'h07) begin
                if (rstk.size() == 0) begin
                    exp_halt_cyc = c + 2; done = 1'b1;
                end else begin
                    mpc = rstk.pop_back(); c += 2;
                end
`endif
            end else if (o[4]) begin
                add_ev(budget, c + 3,  K_T1,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, o);
                add_ev(budget, c + 5,  K_PILHA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, o);
                add_ev(budget, c + 7,  K_T2,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, o);
                add_ev(budget, c + 9,  K_PILHA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, o);
                add_ev(budget, c + 11, K_PILHA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, o);
                mflag = dflag[c + 11];
                mpc = mpc + 8'd1; c += 12;
            end else begin
                mpc = mpc + 8'd1; c += 2;
            end
        end
        if (exp_halt_cyc >= budget) exp_halt_cyc = -1;
    endtask

    // Reset, release, and record strobe events / pc / halt for budget cycles
    task automatic run_program(input int budget);
        logic [2:0] str, prev_str;
        logic [8:0] ctrl, prev_ctrl;
        ev_t        e;
        reset = 1'b0;
        data_uc = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        obs_ev.delete();
        obs_halt_cyc = -1;
        shape_bad = 0;
        prev_str = '0;
        prev_ctrl = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            data_uc = dflag[c];
            obs_pc[c] = pc;
            if (halt && obs_halt_cyc < 0) obs_halt_cyc = c;
            if (!halt && obs_halt_cyc >= 0) shape_bad++;
            str  = {clk_pilha, clk_temp1, clk_temp2};
            ctrl = {wren, controle_pilha, load_temp1, load_temp2, opcode};
            if (str != 3'b000) begin
                if (!$onehot(str) || c == 0 || prev_str != 3'b000 || ctrl != prev_ctrl)
                    shape_bad++;
                e.cyc  = c;
                e.kind = clk_pilha ? K_PILHA : (clk_temp1 ? K_T1 : K_T2);
                e.wren = wren; e.cp = controle_pilha; e.lt1 = load_temp1; e.lt2 = load_temp2;
                e.chk_din = 1'b0; e.din = din_UC; e.chk_opc = 1'b0; e.opc = opcode;
                obs_ev.push_back(e);
            end
            prev_str  = str;
            prev_ctrl = ctrl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_uc = 1'b0;
        clear_rom();
        #3;
        n_checks++;
        if ({pc, clk_pilha, clk_temp1, clk_temp2, wren, controle_pilha, load_temp1,
             load_temp2, din_UC, opcode, halt} !== 37'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_values got pc=%h din=%h opc=%h halt=%b want all zero",
                     pc, din_UC, opcode, halt);
        end
    endtask

    task automatic test_basic_program();
        int np;
        logic [4:0] wseq;
        clear_rom();
        rom[0] = enc(5'h01, 8'h00); rom[1] = 16'd5;
        rom[2] = enc(5'h01, 8'h00); rom[3] = 16'd3;
        rom[4] = enc(5'h10, 8'h00); rom[5] = W_HALT;
        fill_dflag(1'b0);
        run_program(40);
        np = 0; wseq = '0;
        foreach (obs_ev[i]) if (obs_ev[i].kind == K_PILHA) begin
            if (np < 5) wseq[4 - np] = obs_ev[i].wren;
            np++;
        end
        n_checks++;
        if (shape_bad !== 0) begin n_errors++; $display("[TB] FAIL basic_pulse_shape got %0d bad want 0", shape_bad); end
        n_checks++;
        if (np !== 5) begin n_errors++; $display("[TB] FAIL basic_pilha_count got %0d want 5", np); end
        n_checks++;
        if (wseq !== 5'b11001) begin n_errors++; $display("[TB] FAIL basic_push_pop_order got %b want 11001", wseq); end
        if (obs_ev.size() == 7) begin
            n_checks++;
            if (obs_ev[0].din !== 16'd5 || obs_ev[1].din !== 16'd3) begin
                n_errors++;
                $display("[TB] FAIL basic_literals got %0d,%0d want 5,3", obs_ev[0].din, obs_ev[1].din);
            end
            n_checks++;
            if (obs_ev[6].cp !== 1'b1 || obs_ev[6].opc !== 5'h10 || obs_ev[6].wren !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL basic_result_push got cp=%b wren=%b opc=%h want cp=1 wren=1 opc=10",
                         obs_ev[6].cp, obs_ev[6].wren, obs_ev[6].opc);
            end
            n_checks++;
            if (obs_ev[2].kind != K_T1 || obs_ev[2].cyc != 15 || obs_ev[4].kind != K_T2 || obs_ev[4].cyc != 19) begin
                n_errors++;
                $display("[TB] FAIL basic_temp_strobes got t1@%0d t2@%0d want t1@15 t2@19", obs_ev[2].cyc, obs_ev[4].cyc);
            end
        end else begin
            n_checks++; n_errors++;
            $display("[TB] FAIL basic_event_count got %0d want 7", obs_ev.size());
        end
        n_checks++;
        if (obs_halt_cyc !== 26) begin n_errors++; $display("[TB] FAIL basic_halt_cycle got %0d want 26", obs_halt_cyc); end
    endtask

    task automatic test_jc(input logic fv);
        logic [7:0] want;
        clear_rom();
        rom[0] = enc(5'h01, 8'h00); rom[1] = 16'd1;
        rom[2] = enc(5'h01, 8'h00); rom[3] = 16'd2;
        rom[4] = enc(5'h11, 8'h00);
        rom[5] = enc(5'h05, 8'h20);
        fill_dflag(fv);
        run_program(40);
        want = fv ? 8'h20 : 8'h06;
        n_checks++;
        if (obs_pc[26] !== want) begin n_errors++; $display("[TB] FAIL jc_flag%0b_pc got %h want %h", fv, obs_pc[26], want); end
        n_checks++;
        if (obs_halt_cyc !== 28) begin n_errors++; $display("[TB] FAIL jc_flag%0b_halt got %0d want 28", fv, obs_halt_cyc); end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        rom[0]     = enc(5'h04, 8'hFF);
        rom[8'hFF] = 16'h0000;
        fill_dflag(1'b0);
        run_program(8);
        n_checks++;
        if (obs_pc[2] !== 8'hFF) begin n_errors++; $display("[TB] FAIL wrap_jmp_target got %h want ff", obs_pc[2]); end
        n_checks++;
        if (obs_pc[4] !== 8'h00) begin n_errors++; $display("[TB] FAIL wrap_to_zero got %h want 00", obs_pc[4]); end
        n_checks++;
        if (obs_ev.size() !== 0) begin n_errors++; $display("[TB] FAIL wrap_no_strobes got %0d want 0", obs_ev.size()); end
    endtask

    task automatic test_reset_mid_pulse();
        int waited;
        clear_rom();
        rom[0] = enc(5'h01, 8'h00); rom[1] = 16'd5;
        rom[2] = enc(5'h01, 8'h00); rom[3] = 16'd3;
        rom[4] = enc(5'h10, 8'h00); rom[5] = W_HALT;
        fill_dflag(1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!clk_temp2 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!clk_temp2) begin
            n_errors++;
            $display("[TB] FAIL midreset_wait_temp2 got timeout after %0d cycles want strobe", waited);
        end else begin
            reset = 1'b0;
            #1;
            n_checks++;
            if ({pc, clk_pilha, clk_temp1, clk_temp2, wren, controle_pilha, load_temp1,
                 load_temp2, din_UC, opcode, halt} !== 37'h0) begin
                n_errors++;
                $display("[TB] FAIL midreset_async_clear got pc=%h t2=%b lt2=%b din=%h opc=%h want all zero",
                         pc, clk_temp2, load_temp2, din_UC, opcode);
            end
        end
        run_program(40);
        n_checks++;
        if (obs_pc[0] !== 8'h00 || obs_halt_cyc !== 26 || obs_ev.size() !== 7) begin
            n_errors++;
            $display("[TB] FAIL midreset_restart got pc0=%h halt@%0d ev=%0d want 00 26 7",
                     obs_pc[0], obs_halt_cyc, obs_ev.size());
        end
    endtask

`ifdef UC_CALL_RET_EN
    task automatic test_call_ret();
        clear_rom();
        rom[0]     = enc(5'h04, 8'h10);
        rom[8'h10] = enc(5'h06, 8'h40);
        rom[8'h40] = enc(5'h07, 8'h00);
        fill_dflag(1'b0);
        run_program(12);
        n_checks++;
        if (obs_pc[4] !== 8'h40 || obs_pc[6] !== 8'h11) begin
            n_errors++;
            $display("[TB] FAIL call_ret got call@%h ret@%h want 40 11", obs_pc[4], obs_pc[6]);
        end
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = enc(5'h06, 8'(i + 1));
        rom[5] = 16'h0000;
        run_program(16);
        n_checks++;
        if (obs_halt_cyc !== 10) begin
            n_errors++;
            $display("[TB] FAIL call_overflow_halt got %0d want 10", obs_halt_cyc);
        end
    endtask
`endif

    task automatic test_random(input int n_prog, input int budget);
        int         sel;
        logic [4:0] o;
        logic [10:0] low;
        logic       ok;
        int         n;
        for (int p = 0; p < n_prog; p++) begin
            clear_rom();
            for (int a = 0; a < 48; a++) begin
                sel = $urandom_range(0, 9);
                low = 11'($urandom);
                case (sel)
                    0:       o = 5'h00;
                    1, 2:    o = 5'h01;
                    3:       o = 5'h02;
                    4:       begin o = 5'h04; low = {3'b000, 8'($urandom_range(0, 47))}; end
                    5:       begin o = 5'h05; low = {3'b000, 8'($urandom_range(0, 47))}; end
                    6, 7, 8: o = 5'($urandom_range(16, 30));
                    default: o = 5'($urandom_range(6, 15));
                endcase
                rom[a] = {o, low};
            end
            for (int i = 0; i < MAX_CYC + 16; i++) dflag[i] = 1'($urandom);
            run_model(budget);
            run_program(budget);
            n_checks++;
            if (shape_bad !== 0) begin n_errors++; $display("[TB] FAIL rand%0d_pulse_shape got %0d bad want 0", p, shape_bad); end
            for (int c = 0; c < budget; c++) if (exp_is_fetch[c]) begin
                n_checks++;
                if (obs_pc[c] !== exp_fetch_pc[c]) begin
                    n_errors++;
                    $display("[TB] FAIL rand%0d_fetch_pc cyc=%0d got %h want %h", p, c, obs_pc[c], exp_fetch_pc[c]);
                end
            end
            n_checks++;
            if (obs_halt_cyc !== exp_halt_cyc) begin
                n_errors++;
                $display("[TB] FAIL rand%0d_halt_cycle got %0d want %0d", p, obs_halt_cyc, exp_halt_cyc);
            end
            n_checks++;
            if (obs_ev.size() !== exp_ev.size()) begin
                n_errors++;
                $display("[TB] FAIL rand%0d_event_count got %0d want %0d", p, obs_ev.size(), exp_ev.size());
            end
            n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
            for (int i = 0; i < n; i++) begin
                ok = (obs_ev[i].cyc == exp_ev[i].cyc) && (obs_ev[i].kind == exp_ev[i].kind) &&
                     (obs_ev[i].wren === exp_ev[i].wren) && (obs_ev[i].cp === exp_ev[i].cp) &&
                     (obs_ev[i].lt1 === exp_ev[i].lt1) && (obs_ev[i].lt2 === exp_ev[i].lt2) &&
                     (!exp_ev[i].chk_din || obs_ev[i].din === exp_ev[i].din) &&
                     (!exp_ev[i].chk_opc || obs_ev[i].opc === exp_ev[i].opc);
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("[TB] FAIL rand%0d_event%0d got cyc=%0d k=%0d w=%b cp=%b l=%b%b din=%h opc=%h want cyc=%0d k=%0d w=%b cp=%b l=%b%b din=%h opc=%h",
                             p, i, obs_ev[i].cyc, obs_ev[i].kind, obs_ev[i].wren, obs_ev[i].cp,
                             obs_ev[i].lt1, obs_ev[i].lt2, obs_ev[i].din, obs_ev[i].opc,
                             exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].wren, exp_ev[i].cp,
                             exp_ev[i].lt1, exp_ev[i].lt2, exp_ev[i].din, exp_ev[i].opc);
                end
            end
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_basic_program();
        test_jc(1'b1);
        test_jc(1'b0);
        test_pc_wrap();
        test_reset_mid_pulse();
`ifdef UC_CALL_RET_EN
        test_call_ret();
`endif
        test_random(6, 400);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
